// File: rtl/or16_rr_arbiter.sv
// or16_rr_arbiter: round-robin arbiter for the shared, flopped OR_16b resource.
// One-hot registered grant, bounded hold with preemption, registered any_req.
module or16_rr_arbiter #(
  parameter int N        = 16,
  parameter int ID_W     = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_req
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic            gnt_valid_q;
  logic [ID_W-1:0] gnt_id_q;
  logic            any_req_q;
  logic [3:0]      ptr_q;
  logic [7:0]      hcnt_q;

  logic [N-1:0]    cand;
  logic [N-1:0]    hit;
  logic            win_found;
  logic [3:0]      win_off;
  logic [4:0]      win_sum;
  logic [3:0]      win_idx;
  logic [3:0]      win_next_ptr;
  logic [N-1:0]    win_onehot;
  logic            holder_req;
  logic            preempt_ok;
  logic            take;

  // The holder is never a candidate: on release its req is already low,
  // and on preemption it must be skipped.
  assign cand = req & ~gnt_q;

  // hit[k] = cand[(ptr + k) mod N]; the doubled vector makes the wrap free.
  assign hit = N'({cand, cand} >> ptr_q);

  always_comb begin
    win_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) win_off = 4'(k);
    end
  end

  assign win_found    = |hit;
  assign win_sum      = {1'b0, ptr_q} + {1'b0, win_off};
  assign win_idx      = (win_sum >= 5'(N)) ? 4'(win_sum - 5'(N)) : 4'(win_sum);
  assign win_next_ptr = (win_idx == 4'(N - 1)) ? 4'd0 : win_idx + 4'd1;

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == 4'(gi));
  end

  assign holder_req = |(req & gnt_q);
  assign preempt_ok = (LOCK_MAX != 0) && (hcnt_q >= 8'(LOCK_MAX)) && win_found;

  always_comb begin
    take = 1'b0;
    case (state_q)
      IDLE:  take = win_found;
      GRANT: take = win_found && (!holder_req || preempt_ok);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      any_req_q   <= 1'b0;
      ptr_q       <= '0;
      hcnt_q      <= '0;
    end else begin
      any_req_q <= |req;
      if (take) begin
        state_q     <= GRANT;
        gnt_q       <= win_onehot;
        gnt_valid_q <= 1'b1;
        gnt_id_q    <= win_idx[ID_W-1:0];
        ptr_q       <= win_next_ptr;
        hcnt_q      <= 8'd1;
      end else begin
        case (state_q)
          IDLE: begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
          end
          GRANT: begin
            if (!holder_req) begin
              // Release with nobody waiting: ptr keeps pointing past the old holder.
              state_q     <= IDLE;
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
              gnt_id_q    <= '0;
              hcnt_q      <= '0;
            end else if (hcnt_q != 8'hFF) begin
              hcnt_q <= hcnt_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign any_req   = any_req_q;

endmodule

// File: tb/tb_or16_rr_arbiter.sv
// Bench for or16_rr_arbiter: two instances (LOCK_MAX=8 and LOCK_MAX=0) share
// req/rst and are compared every cycle against a behavioural arbiter model.
module tb_or16_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] req = '0;

  logic [15:0] gnt, gnt0;
  logic        gv, gv0;
  logic [3:0]  gid, gid0;
  logic        any, any0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  or16_rr_arbiter #(.N(16), .ID_W(4), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_valid(gv), .gnt_id(gid), .any_req(any)
  );

  or16_rr_arbiter #(.N(16), .ID_W(4), .LOCK_MAX(0)) dut0 (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt0), .gnt_valid(gv0), .gnt_id(gid0), .any_req(any0)
  );

  // Behavioural model, index 0 -> lock 8, index 1 -> lock 0.
  bit   m_busy[2];
  int   m_hold[2];
  int   m_ptr[2];
  int   m_hcnt[2];
  logic m_any[2];

  function automatic int find(input logic [15:0] r, input int start, input int excl);
    for (int k = 0; k < 16; k++) begin
      int i;
      i = (start + k) % 16;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_gnt(input int k);
    logic [15:0] one;
    one = 16'h1;
    return m_busy[k] ? (one << m_hold[k]) : 16'h0;
  endfunction

  function automatic logic [3:0] exp_id(input int k);
    return m_busy[k] ? 4'(m_hold[k]) : 4'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_hold[k] = 0; m_ptr[k] = 0; m_hcnt[k] = 0; m_any[k] = 1'b0;
    end
  endtask

  task automatic grant_to(input int k, input int w);
    m_busy[k] = 1; m_hold[k] = w; m_ptr[k] = (w + 1) % 16; m_hcnt[k] = 1;
  endtask

  task automatic model_step(input int k, input logic [15:0] r);
    int lock;
    int w;
    lock = (k == 0) ? 8 : 0;
    m_any[k] = |r;
    if (!m_busy[k]) begin
      w = find(r, m_ptr[k], -1);
      if (w >= 0) grant_to(k, w);
    end else if (!r[m_hold[k]]) begin
      w = find(r, m_ptr[k], -1);
      if (w >= 0) grant_to(k, w);
      else m_busy[k] = 0;
    end else begin
      w = find(r, m_ptr[k], m_hold[k]);
      if (lock != 0 && m_hcnt[k] >= lock && w >= 0) grant_to(k, w);
      else if (m_hcnt[k] < 255) m_hcnt[k]++;
    end
  endtask

  task automatic tick(input logic [15:0] r);
    req = r;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0, r);
      model_step(1, r);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick(16'hFFFF);
      total++; if (gnt !== 16'h0 || gv !== 1'b0 || gid !== 4'd0 || any !== 1'b0) begin
        bad++; $display("FAIL reset_outs c=%0d got gnt=%h v=%b id=%0d any=%b exp all 0", c, gnt, gv, gid, any);
      end
      total++; if (gnt0 !== 16'h0 || any0 !== 1'b0) begin
        bad++; $display("FAIL reset_outs0 c=%0d got gnt=%h any=%b exp 0", c, gnt0, any0);
      end
    end
    rst = 1'b0;
    tick(16'hFFFF);
    total++; if (gnt !== 16'h0001 || gid !== 4'd0 || gv !== 1'b1 || any !== 1'b1) begin
      bad++; $display("FAIL first_grant got gnt=%h id=%0d v=%b any=%b exp 0001/0/1/1", gnt, gid, gv, any);
    end
    total++; if (gnt0 !== 16'h0001) begin
      bad++; $display("FAIL first_grant0 got=%h exp=0001", gnt0);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] prev;
    tick(16'h0); tick(16'h0);
    prev = 16'h0;
    for (int c = 0; c < 10; c++) begin
      tick(16'h0011 & ~gnt);
      total++; if (gnt !== exp_gnt(0)) begin
        bad++; $display("FAIL rr_gnt c=%0d got=%h exp=%h", c, gnt, exp_gnt(0));
      end
      total++; if (gv !== 1'b1 || (gnt !== 16'h0001 && gnt !== 16'h0010) || gnt === prev) begin
        bad++; $display("FAIL rr_alternate c=%0d got=%h prev=%h exp other of 0001/0010", c, gnt, prev);
      end
      prev = gnt;
    end
  endtask

  task automatic test_preempt();
    logic [15:0] prev;
    logic [15:0] g0_first;
    int run;
    tick(16'h0); tick(16'h0);
    prev = 16'h0; run = 0; g0_first = 16'h0;
    for (int c = 0; c < 48; c++) begin
      tick(16'h0003);
      if (c == 0) g0_first = exp_gnt(1);
      total++; if (gnt !== exp_gnt(0) || gid !== exp_id(0)) begin
        bad++; $display("FAIL pre_gnt c=%0d got=%h/%0d exp=%h/%0d", c, gnt, gid, exp_gnt(0), exp_id(0));
      end
      if (gnt !== prev) begin
        if (prev != 16'h0) begin
          total++; if (run != 8) begin
            bad++; $display("FAIL pre_run c=%0d got=%0d exp=8", c, run);
          end
        end
        run = 1; prev = gnt;
      end else run++;
      total++; if (gnt0 !== g0_first) begin
        bad++; $display("FAIL nolock_hold c=%0d got=%h exp=%h", c, gnt0, g0_first);
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [15:0] other;
    other = 16'h0003 & ~gnt0;
    tick(other);
    total++; if (gnt0 !== other || gnt0 !== exp_gnt(1)) begin
      bad++; $display("FAIL nolock_release got=%h exp=%h", gnt0, other);
    end
    for (int c = 0; c < 20; c++) begin
      tick(16'h0003);
      total++; if (gnt0 !== other || gid0 !== exp_id(1)) begin
        bad++; $display("FAIL nolock_keep c=%0d got=%h/%0d exp=%h/%0d", c, gnt0, gid0, other, exp_id(1));
      end
    end
  endtask

  task automatic test_sole();
    for (int c = 0; c < 300; c++) begin
      tick(16'h0020);
      total++; if (gnt !== 16'h0020 || gid !== 4'd5 || gnt0 !== 16'h0020) begin
        bad++; $display("FAIL sole c=%0d got=%h/%0d gnt0=%h exp=0020/5", c, gnt, gid, gnt0);
      end
    end
  endtask

  task automatic test_wrap();
    tick(16'h0); tick(16'h0);
    tick(16'h8000);
    total++; if (gnt !== 16'h8000 || gid !== 4'd15) begin
      bad++; $display("FAIL wrap_15 got=%h/%0d exp=8000/15", gnt, gid);
    end
    tick(16'h0004);
    total++; if (gnt !== 16'h0004 || gid !== 4'd2 || gv !== 1'b1) begin
      bad++; $display("FAIL wrap_2 got=%h/%0d/%b exp=0004/2/1", gnt, gid, gv);
    end
    tick(16'h8004);
    total++; if (gnt !== 16'h0004 || gnt !== exp_gnt(0)) begin
      bad++; $display("FAIL wrap_hold2 got=%h exp=0004", gnt);
    end
    tick(16'h8000);
    total++; if (gnt !== 16'h8000 || gid !== 4'd15) begin
      bad++; $display("FAIL wrap_back15 got=%h/%0d exp=8000/15", gnt, gid);
    end
  endtask

  task automatic test_async_reset();
    tick(16'h0); tick(16'h0);
    tick(16'h0100);
    total++; if (gnt !== 16'h0100) begin
      bad++; $display("FAIL ar_pre got=%h exp=0100", gnt);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (gnt !== 16'h0 || gv !== 1'b0 || gid !== 4'd0 || gnt0 !== 16'h0) begin
      bad++; $display("FAIL ar_drop got gnt=%h v=%b id=%0d gnt0=%h exp 0", gnt, gv, gid, gnt0);
    end
    tick(16'h0100);
    rst = 1'b0;
    tick(16'h0100);
    total++; if (gnt !== 16'h0100 || gid !== 4'd8 || gv !== 1'b1) begin
      bad++; $display("FAIL ar_regrant got=%h/%0d/%b exp=0100/8/1", gnt, gid, gv);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int c = 0; c < 400; c++) begin
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) != 0) r = r | gnt;
      if ($urandom_range(0, 15) == 0) r = 16'h0;
      tick(r);
      total++; if (gnt !== exp_gnt(0) || gid !== exp_id(0) || gv !== m_busy[0] || any !== m_any[0]) begin
        bad++; $display("FAIL rnd_l8 c=%0d req=%h got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                        c, r, gnt, gid, gv, any, exp_gnt(0), exp_id(0), m_busy[0], m_any[0]);
      end
      total++; if (gnt0 !== exp_gnt(1) || gid0 !== exp_id(1) || gv0 !== m_busy[1] || any0 !== m_any[1]) begin
        bad++; $display("FAIL rnd_l0 c=%0d req=%h got=%h/%0d/%b/%b exp=%h/%0d/%b/%b",
                        c, r, gnt0, gid0, gv0, any0, exp_gnt(1), exp_id(1), m_busy[1], m_any[1]);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_preempt();
    test_no_preempt();
    test_sole();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
